pipe_hazard_ctrl: RTL and testbench

Central sequencer for the 5-stage NPC pipeline (IF, ID, EX, MEM, WB). Each cycle it drives the PC enable, the PC redirect select and the enable/flush of the four pipeline registers (ID, EX, MEM, WB). Inputs are decode register usage, EX-stage load/branch status, the data-memory handshake and instruction-fetch readiness. It resolves load-use hazards, branch/jump redirects, multi-cycle data-memory waits and fetch waits, in a fixed priority order.

---
 rtl/pipe_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencer (PC/stage enables, flushes, redirect) with load-use, redirect, mem-wait and fetch-wait handling; optional perf counters under YSYX_22050133_PIPE_PERF_EN
module pipe_hazard_ctrl #(
  parameter int LDUSE_BUBBLES = 1,
  parameter int MEM_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        if_ready,
  output logic        pc_en,
  output logic        pcsrc,
  output logic        id_en,
  output logic        ex_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        wb_flush,
  output logic [1:0]  state,
`ifdef YSYX_22050133_PIPE_PERF_EN
  output logic [31:0] perf_stall_lduse,
  output logic [31:0] perf_stall_mem,
  output logic [31:0] perf_flush_redir,
`endif
  output logic        err
);
  typedef enum logic [1:0] {RUN = 2'b00, LDUSE = 2'b01, MWAIT = 2'b10, RSVD = 2'b11} state_t;
  localparam logic [1:0] BL = 2'(LDUSE_BUBBLES - 1);
  localparam logic [7:0] TO = 8'(MEM_TIMEOUT);
  state_t     st;
  logic [1:0] cnt, cnt_nx;
  logic [7:0] tcnt, tn;
  logic       mwait, redir, lduse, stall, fwait;
  assign mwait  = mem_req & ~mem_ready;
  assign redir  = ex_branch_taken & ~mwait;
  assign lduse  = ex_is_load & (ex_rd != 5'd0) &
                  ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign stall  = ~mwait & ~ex_branch_taken & ((cnt != 2'd0) | lduse);
  assign fwait  = ~mwait & ~ex_branch_taken & ~stall & ~if_ready;
  assign cnt_nx = (cnt != 2'd0) ? cnt - 2'd1 : BL;
  assign tn     = (tcnt == 8'hff) ? tcnt : tcnt + 8'd1;
  assign state  = st;
  always_comb begin
    pc_en    = rst & ~mwait & ~stall & ~fwait;
    pcsrc    = rst & redir;
    id_en    = rst & ~mwait & ~stall;
    ex_en    = rst & ~mwait;
    mem_en   = rst & ~mwait;
    wb_en    = rst;
    id_flush = ~rst | redir | fwait;
    ex_flush = ~rst | redir | stall;
    wb_flush = ~rst | mwait;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= RUN;
      cnt  <= 2'd0;
      tcnt <= 8'd0;
      err  <= 1'b0;
    end else begin
      if (mwait) begin
        st   <= MWAIT;
        tcnt <= tn;
      end else begin
        tcnt <= 8'd0;
        if (ex_branch_taken) begin
          st  <= RUN;
          cnt <= 2'd0;
        end else if (stall) begin
          cnt <= cnt_nx;
          st  <= (cnt_nx != 2'd0) ? LDUSE : RUN;
        end else st <= RUN;
      end
      if ((MEM_TIMEOUT != 0 && mwait && tn >= TO) || (ex_is_load & ex_branch_taken)) err <= 1'b1;
    end
  end
`ifdef YSYX_22050133_PIPE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_lduse <= 32'd0;
      perf_stall_mem   <= 32'd0;
      perf_flush_redir <= 32'd0;
    end else begin
      perf_stall_lduse <= perf_stall_lduse + {31'd0, stall};
      perf_stall_mem   <= perf_stall_mem + {31'd0, mwait};
      perf_flush_redir <= perf_flush_redir + {31'd0, redir};
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl (LDUSE_BUBBLES=2, MEM_TIMEOUT=4)
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_is_load, ex_branch_taken, mem_req, mem_ready, if_ready;
  logic pc_en, pcsrc, id_en, ex_en, mem_en, wb_en, id_flush, ex_flush, wb_flush, err;
  logic [1:0] state;
  logic [8:0] ctl;
  int checks = 0, failures = 0;
  localparam logic [8:0] RST_V = 9'b0_0_0000_111;
  localparam logic [8:0] RUN_V = 9'b1_0_1111_000;
  localparam logic [8:0] LD_V  = 9'b0_0_0111_010;
  localparam logic [8:0] MW_V  = 9'b0_0_0001_001;
  localparam logic [8:0] RD_V  = 9'b1_1_1111_110;
  always #5 clk = ~clk;
  assign ctl = {pc_en, pcsrc, id_en, ex_en, mem_en, wb_en, id_flush, ex_flush, wb_flush};
  pipe_hazard_ctrl #(.LDUSE_BUBBLES(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .if_ready(if_ready), .pc_en(pc_en), .pcsrc(pcsrc), .id_en(id_en), .ex_en(ex_en),
    .mem_en(mem_en), .wb_en(wb_en), .id_flush(id_flush), .ex_flush(ex_flush),
    .wb_flush(wb_flush), .state(state), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; if_ready = 1'b1;
  endtask
  initial begin
    rst = 1'b0;
    idle();
    #2;
    chk("rst_ctl", 32'(ctl), 32'(RST_V));
    chk("rst_state", 32'(state), 0);
    chk("rst_err", 32'(err), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("run_ctl", 32'(ctl), 32'(RUN_V));
    chk("run_state", 32'(state), 0);
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #1 chk("x0_no_haz", 32'(ctl), 32'(RUN_V));
    ex_rd = 5'd9; id_rs2 = 5'd9; id_rs1 = 5'd3;
    #1 chk("unused_no_haz", 32'(ctl), 32'(RUN_V));
    ex_rd = 5'd5; id_rs1 = 5'd5;
    #1 chk("ldu1_ctl", 32'(ctl), 32'(LD_V));
    tick();
    chk("ldu1_state", 32'(state), 1);
    #1 chk("ldu2_ctl", 32'(ctl), 32'(LD_V));
    tick();
    chk("ldu2_state", 32'(state), 0);
    idle();
    #1 chk("ldu_done", 32'(ctl), 32'(RUN_V));
    if_ready = 1'b0;
    #1 chk("fw_ctl", 32'({pc_en, pcsrc, ex_en, mem_en, wb_en, id_flush, ex_flush, wb_flush}), 32'h3C);
    tick();
    chk("fw_state", 32'(state), 0);
    if_ready = 1'b1; mem_req = 1'b1; ex_branch_taken = 1'b1;
    #1 chk("mw_over_br", 32'(ctl), 32'(MW_V));
    tick();
    chk("mw1_state", 32'(state), 2);
    ex_branch_taken = 1'b0;
    for (int i = 2; i <= 3; i++) begin
      #1 chk("mw_ctl", 32'(ctl), 32'(MW_V));
      tick();
      chk("mw_state", 32'(state), 2);
    end
    chk("mw_err", 32'(err), 0);
    mem_ready = 1'b1;
    #1 chk("mw_rdy_ctl", 32'(ctl), 32'(RUN_V));
    tick();
    chk("mw_rdy_state", 32'(state), 0);
    idle();
    ex_branch_taken = 1'b1;
    #1 chk("redir_ctl", 32'(ctl), 32'(RD_V));
    tick();
    chk("redir_state", 32'(state), 0);
    chk("redir_err", 32'(err), 0);
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
    #1 chk("redir_ldu_ctl", 32'(ctl), 32'(RD_V));
    tick();
    chk("redir_ldu_state", 32'(state), 0);
    chk("illegal_err", 32'(err), 1);
    idle();
    #1 chk("post_redir_ctl", 32'(ctl), 32'(RUN_V));
    #1 rst = 1'b0;
    #1 chk("rst_clr_err", 32'(err), 0);
    rst = 1'b1;
    mem_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("to_err", 32'(err), (i >= 4) ? 1 : 0);
    end
    mem_ready = 1'b1;
    tick();
    chk("to_sticky", 32'(err), 1);
    chk("to_state", 32'(state), 0);
    mem_ready = 1'b0;
    tick();
    tick();
    chk("mid_mw_state", 32'(state), 2);
    #2 rst = 1'b0;
    #1 chk("async_rst_ctl", 32'(ctl), 32'(RST_V));
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_err", 32'(err), 0);
    idle();
    tick();
    rst = 1'b1;
    tick();
    chk("final_run", 32'(ctl), 32'(RUN_V));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
